// File: rtl/mdio_pkg.sv
// MDIO Clause 22 master: shared state type, frame constants
// and command-word builder.
package mdio_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_CMD,
      S_TA,
      S_DATA,
      S_END
   } mdio_state_t;

   localparam logic [1:0] MDIO_ST    = 2'b01;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;
   localparam logic [1:0] MDIO_OP_RD = 2'b10;
   localparam logic [1:0] MDIO_TA_WR = 2'b10;
   localparam int MDIO_CMD_BITS  = 14;
   localparam int MDIO_DATA_BITS = 16;

   function automatic logic [13:0] mdio_cmd(
      input logic       wr,
      input logic [4:0] phy,
      input logic [4:0] reg_addr
   );
      return {MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD), phy, reg_addr};
   endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC divider: CLK_DIV cycles low then CLK_DIV cycles high,
// held low and cleared whenever disabled.
module mdio_clkgen #(
   parameter int CLK_DIV = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic mdc,
   output logic fall_strobe,
   output logic rise_strobe
);

   logic [7:0] cnt;
   logic       wrap;

   // Strobes flag the cycle whose closing edge toggles MDC.
   assign wrap        = en && (cnt == 8'(CLK_DIV - 1));
   assign fall_strobe = wrap && mdc;
   assign rise_strobe = wrap && !mdc;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else begin
         cnt <= wrap ? 8'd0 : cnt + 8'd1;
         if (wrap) mdc <= ~mdc;
      end
   end

endmodule

// File: rtl/mdio_master.sv
// IEEE 802.3 Clause 22 MDIO master: serialises one register
// read or write per request into an MDC/MDIO frame.
module mdio_master
   import mdio_pkg::*;
#(
   parameter int CLK_DIV      = 20,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [4:0]  i_req_phyaddr,
   input  logic [4:0]  i_req_regaddr,
   input  logic [15:0] i_req_wdata,
   output logic        o_resp_valid,
   output logic [15:0] o_resp_rdata,
   output logic        o_busy,
   output logic        o_mdc,
   output logic        o_mdio,
   output logic        o_mdio_t,
   input  logic        i_mdio
);

   mdio_state_t state;
   logic [4:0]  cnt;
   logic        run;
   logic        wr_q;
   logic [15:0] wdata_q;
   logic [15:0] tx_sr;
   logic [15:0] rx_sr;
   logic [15:0] rx_next;
   logic [1:0]  mdio_sync;
   logic        rise_q;
   logic        smp;
   logic        fall_strobe;
   logic        rise_strobe;

   mdio_clkgen #(
      .CLK_DIV(CLK_DIV)
   ) u_clkgen (
      .clk        (i_clk),
      .rst        (i_rst),
      .en         (run),
      .mdc        (o_mdc),
      .fall_strobe(fall_strobe),
      .rise_strobe(rise_strobe)
   );

   // Sample two cycles after the MDC rise to absorb the synchroniser.
   always_comb begin
      rx_next = rx_sr;
      if (smp) rx_next = {rx_sr[14:0], mdio_sync[1]};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         run          <= 1'b0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         tx_sr        <= '0;
         rx_sr        <= '0;
         mdio_sync    <= 2'b11;
         rise_q       <= 1'b0;
         smp          <= 1'b0;
         o_req_ready  <= 1'b1;
         o_busy       <= 1'b0;
         o_resp_valid <= 1'b0;
         o_resp_rdata <= '0;
         o_mdio       <= 1'b1;
         o_mdio_t     <= 1'b1;
      end else begin
         mdio_sync    <= {mdio_sync[0], i_mdio};
         rise_q       <= rise_strobe;
         smp          <= rise_q;
         rx_sr        <= rx_next;
         o_resp_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (i_req_valid && o_req_ready) begin
                  wr_q        <= i_req_write;
                  wdata_q     <= i_req_wdata;
                  tx_sr       <= {mdio_cmd(i_req_write, i_req_phyaddr,
                                           i_req_regaddr), 2'b00};
                  rx_sr       <= '0;
                  cnt         <= 5'(PREAMBLE_LEN - 1);
                  run         <= 1'b1;
                  o_mdio      <= 1'b1;
                  o_mdio_t    <= 1'b0;
                  o_req_ready <= 1'b0;
                  o_busy      <= 1'b1;
                  state       <= S_PRE;
               end
            end
            S_PRE: begin
               if (fall_strobe) begin
                  if (cnt == 5'd0) begin
                     cnt    <= 5'(MDIO_CMD_BITS - 1);
                     o_mdio <= tx_sr[15];
                     tx_sr  <= {tx_sr[14:0], 1'b0};
                     state  <= S_CMD;
                  end else begin
                     cnt <= cnt - 5'd1;
                  end
               end
            end
            S_CMD: begin
               if (fall_strobe) begin
                  if (cnt == 5'd0) begin
                     cnt      <= 5'd1;
                     o_mdio   <= wr_q ? MDIO_TA_WR[1] : 1'b1;
                     o_mdio_t <= ~wr_q;
                     state    <= S_TA;
                  end else begin
                     cnt    <= cnt - 5'd1;
                     o_mdio <= tx_sr[15];
                     tx_sr  <= {tx_sr[14:0], 1'b0};
                  end
               end
            end
            S_TA: begin
               if (fall_strobe) begin
                  if (cnt == 5'd0) begin
                     cnt    <= 5'(MDIO_DATA_BITS - 1);
                     o_mdio <= wr_q ? wdata_q[15] : 1'b1;
                     tx_sr  <= {wdata_q[14:0], 1'b0};
                     state  <= S_DATA;
                  end else begin
                     cnt    <= 5'd0;
                     o_mdio <= wr_q ? MDIO_TA_WR[0] : 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (fall_strobe) begin
                  if (cnt == 5'd0) begin
                     run          <= 1'b0;
                     o_mdio       <= 1'b1;
                     o_mdio_t     <= 1'b1;
                     o_resp_valid <= 1'b1;
                     o_resp_rdata <= wr_q ? 16'h0000 : rx_next;
                     state        <= S_END;
                  end else begin
                     cnt    <= cnt - 5'd1;
                     o_mdio <= wr_q ? tx_sr[15] : 1'b1;
                     tx_sr  <= {tx_sr[14:0], 1'b0};
                  end
               end
            end
            S_END: begin
               o_req_ready <= 1'b1;
               o_busy      <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Randomised frame-level bench for mdio_master against a
// bit-stream reference model (two parameter sets).
module tb_mdio_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [4:0]  phy;
   logic [4:0]  regad;
   logic [15:0] wdata;
   logic        mdio_in;
   logic        sel;

   logic        ready1, resp_valid1, busy1, mdc1, mdio1, t1;
   logic        ready2, resp_valid2, busy2, mdc2, mdio2, t2;
   logic [15:0] rdata1, rdata2;

   logic        ready, resp_valid, busy, mdc, mdio, mdio_t;
   logic [15:0] rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mdio_master #(.CLK_DIV(4), .PREAMBLE_LEN(32)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid & ~sel),
      .o_req_ready  (ready1),
      .i_req_write  (req_write),
      .i_req_phyaddr(phy),
      .i_req_regaddr(regad),
      .i_req_wdata  (wdata),
      .o_resp_valid (resp_valid1),
      .o_resp_rdata (rdata1),
      .o_busy       (busy1),
      .o_mdc        (mdc1),
      .o_mdio       (mdio1),
      .o_mdio_t     (t1),
      .i_mdio       (mdio_in)
   );

   mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(1)) u_dut_min (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid & sel),
      .o_req_ready  (ready2),
      .i_req_write  (req_write),
      .i_req_phyaddr(phy),
      .i_req_regaddr(regad),
      .i_req_wdata  (wdata),
      .o_resp_valid (resp_valid2),
      .o_resp_rdata (rdata2),
      .o_busy       (busy2),
      .o_mdc        (mdc2),
      .o_mdio       (mdio2),
      .o_mdio_t     (t2),
      .i_mdio       (mdio_in)
   );

   assign ready      = sel ? ready2 : ready1;
   assign resp_valid = sel ? resp_valid2 : resp_valid1;
   assign busy       = sel ? busy2 : busy1;
   assign mdc        = sel ? mdc2 : mdc1;
   assign mdio       = sel ? mdio2 : mdio1;
   assign mdio_t     = sel ? t2 : t1;
   assign rdata      = sel ? rdata2 : rdata1;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Whole frame as seen on MDC rises, MSB = first preamble bit.
   function automatic logic [63:0] ref_bits(input bit wr,
      input logic [4:0] ph, input logic [4:0] rg,
      input logic [15:0] d, input int p);
      logic [63:0] f;
      f = 64'd0;
      for (int i = 0; i < p; i++) f = (f << 1) | 64'd1;
      f = (f << 2) | 64'd1;
      f = (f << 2) | (wr ? 64'd1 : 64'd2);
      f = (f << 5) | 64'(ph);
      f = (f << 5) | 64'(rg);
      f = (f << 2) | (wr ? 64'd2 : 64'd3);
      f = (f << 16) | 64'(d);
      return f;
   endfunction

   function automatic logic phy_bit(input bit wr, input int idx,
      input int p, input logic [15:0] pd);
      if (wr) return 1'b1;
      if (idx == p + 15) return 1'b0;
      if (idx >= p + 16 && idx < p + 32) return pd[15 - (idx - p - 16)];
      return 1'b1;
   endfunction

   task automatic run_frame(input bit wr, input logic [4:0] ph,
      input logic [4:0] rg, input logic [15:0] d,
      input logic [15:0] pd, input bit hold);
      int dv, pl, nb, cyc, lat, bad, budget;
      logic [63:0] gb, gt, msk, eb;
      logic [15:0] rd;
      logic pm;
      dv = sel ? 2 : 4;
      pl = sel ? 1 : 32;
      budget = 2 * dv * (pl + 32) + 20;
      @(negedge clk);
      for (int i = 0; i < 2000 && !ready; i++) @(negedge clk);
      check("accept_ready", 64'(ready), 64'd1);
      req_valid = 1'b1;
      req_write = wr;
      phy = ph;
      regad = rg;
      wdata = d;
      @(posedge clk);
      #1;
      if (hold) begin
         req_write = !wr;
         phy = ~ph;
         regad = ~rg;
         wdata = ~d;
      end else begin
         req_valid = 1'b0;
      end
      cyc = 1; nb = 0; gb = '0; gt = '0; pm = 1'b0;
      lat = 0; bad = 0; rd = '0;
      while (cyc < budget) begin
         if (mdc && !pm) begin
            gb = {gb[62:0], mdio};
            gt = {gt[62:0], mdio_t};
            nb++;
         end
         if ((!mdc && pm) || cyc == 1) mdio_in = phy_bit(wr, nb, pl, pd);
         if (resp_valid) begin
            lat = cyc;
            rd = rdata;
            check("end_pins", {61'd0, mdc, mdio_t, mdio}, 64'd3);
            break;
         end
         if (!busy || ready) bad++;
         pm = mdc;
         @(posedge clk);
         #1;
         cyc++;
      end
      mdio_in = 1'b1;
      msk = wr ? ~64'd0 : ~64'h3FFFF;
      eb = ref_bits(wr, ph, rg, d, pl);
      check("latency", 64'(lat), 64'(2 * dv * (pl + 32) + 1));
      check("nbits", 64'(nb), 64'(pl + 32));
      check("bits", gb & msk, eb & msk);
      check("tristate", gt, wr ? 64'd0 : 64'h3FFFF);
      check("rdata", 64'(rd), wr ? 64'd0 : 64'(pd));
      check("busy_hold", 64'(bad), 64'd0);
      @(posedge clk);
      #1;
      check("post_end", {60'd0, resp_valid, ready, busy, mdc}, 64'h4);
   endtask

   initial begin
      int bad;
      logic [4:0]  rp, rr;
      logic [15:0] rw, rpd;
      sel = 1'b0;
      rst = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      phy = '0;
      regad = '0;
      wdata = '0;
      mdio_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state",
            {41'd0, mdc, mdio, mdio_t, ready, busy, resp_valid, rdata},
            {41'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0});
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if ({mdc, mdio_t, mdio, ready, busy} !== 5'b01110) bad++;
      end
      check("idle", 64'(bad), 64'd0);

      run_frame(1'b1, 5'd1, 5'd0, 16'h1234, 16'h0, 1'b0);
      run_frame(1'b0, 5'd3, 5'd2, 16'h0, 16'h8765, 1'b0);

      rp = 5'($urandom); rr = 5'($urandom); rw = 16'($urandom);
      run_frame(1'b1, rp, rr, rw, 16'h0, 1'b1);
      run_frame(1'b0, ~rp, ~rr, ~rw, 16'($urandom), 1'b0);

      // Abort a write during command bit 5.
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      phy = 5'($urandom);
      regad = 5'($urandom);
      wdata = 16'($urandom);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      begin
         int nb;
         logic pm;
         nb = 0;
         pm = 1'b0;
         for (int i = 0; i < 2000 && nb < 32 + 6; i++) begin
            if (mdc && !pm) nb++;
            pm = mdc;
            @(posedge clk);
            #1;
         end
         check("abort_reached", 64'(nb), 64'd38);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_pins", {59'd0, mdc, mdio_t, busy, ready, mdio},
            64'b01011);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid || mdc) bad++;
      end
      check("abort_quiet", 64'(bad), 64'd0);
      run_frame(1'b0, 5'($urandom), 5'($urandom), 16'h0,
                16'($urandom), 1'b0);

      for (int k = 0; k < 4; k++) begin
         rpd = 16'($urandom);
         run_frame(1'($urandom), 5'($urandom), 5'($urandom),
                   16'($urandom), rpd, 1'b0);
      end

      sel = 1'b1;
      run_frame(1'b0, 5'($urandom), 5'($urandom), 16'h0, 16'hFFFF, 1'b0);
      for (int k = 0; k < 3; k++) begin
         run_frame(1'($urandom), 5'($urandom), 5'($urandom),
                   16'($urandom), 16'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
